// File: rtl/alu_seq_if.sv
// Handshake and data bundle between the datapath controller and alu_seq.
// The controller drives the master side and the ALU implements the slave side.
interface alu_seq_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] r_hi;
    logic             zero;
    logic             carry;
    logic             sign;
    logic             overflow;

    modport master (
        output start, op, a, b,
        input  busy, done, r, r_hi, zero, carry, sign, overflow
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, r, r_hi, zero, carry, sign, overflow
    );
endinterface

// File: rtl/alu_seq.sv
// Registered WIDTH-bit ALU with start/done handshake: single-cycle arithmetic and
// logic ops, signed-overflow flag, and a WIDTH-cycle shift-add unsigned multiply.
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic      clk,
    input  logic      rst_n,
    alu_seq_if.slave  bus
);

    localparam int               CNT_W     = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    localparam logic [3:0] OP_SUB  = 4'd0;
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_NEGB = 4'd2;
    localparam logic [3:0] OP_NEGA = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4;
    localparam logic [3:0] OP_OR   = 4'd5;
    localparam logic [3:0] OP_XOR  = 4'd6;
    localparam logic [3:0] OP_NOTA = 4'd7;
    localparam logic [3:0] OP_MUL  = 4'd8;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_e;

    state_e                 state_q, state_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic [WIDTH-1:0]       r_q, r_d;
    logic [WIDTH-1:0]       r_hi_q, r_hi_d;
    logic                   zero_q, zero_d;
    logic                   carry_q, carry_d;
    logic                   sign_q, sign_d;
    logic                   ovf_q, ovf_d;
    logic [WIDTH-1:0]       mcand_q, mcand_d;
    logic [WIDTH-1:0]       mplier_q, mplier_d;
    logic [2*WIDTH-1:0]     acc_q, acc_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;

    logic [WIDTH-1:0]       add_x_s;
    logic [WIDTH-1:0]       add_y_s;
    logic                   add_cin_s;
    logic [WIDTH:0]         sum_s;
    logic [WIDTH-1:0]       alu_r_s;
    logic                   alu_zero_s;
    logic                   alu_carry_s;
    logic                   alu_sign_s;
    logic                   alu_ovf_s;
    logic [WIDTH:0]         step_sum_s;
    logic [2*WIDTH-1:0]     acc_step_s;

    // Adder operand selection: SUB and NEG are built as x + ~y + 1.
    always_comb begin
        add_x_s   = bus.a;
        add_y_s   = bus.b;
        add_cin_s = 1'b0;
        case (bus.op)
            OP_SUB: begin
                add_y_s   = ~bus.b;
                add_cin_s = 1'b1;
            end
            OP_NEGB: begin
                add_x_s   = {WIDTH{1'b0}};
                add_y_s   = ~bus.b;
                add_cin_s = 1'b1;
            end
            OP_NEGA: begin
                add_x_s   = {WIDTH{1'b0}};
                add_y_s   = ~bus.a;
                add_cin_s = 1'b1;
            end
            default: begin
                add_cin_s = 1'b0;
            end
        endcase
        sum_s = {1'b0, add_x_s} + {1'b0, add_y_s} + {{WIDTH{1'b0}}, add_cin_s};
    end

    // Single-cycle result and flags; reserved codes fall to R=0, zero=1.
    always_comb begin
        alu_r_s     = {WIDTH{1'b0}};
        alu_carry_s = 1'b0;
        alu_ovf_s   = 1'b0;
        case (bus.op)
            OP_SUB, OP_ADD, OP_NEGB, OP_NEGA: begin
                alu_r_s     = sum_s[WIDTH-1:0];
                alu_carry_s = sum_s[WIDTH];
                alu_ovf_s   = (add_x_s[WIDTH-1] == add_y_s[WIDTH-1]) &&
                              (sum_s[WIDTH-1] != add_x_s[WIDTH-1]);
            end
            OP_AND:  alu_r_s = bus.a & bus.b;
            OP_OR:   alu_r_s = bus.a | bus.b;
            OP_XOR:  alu_r_s = bus.a ^ bus.b;
            OP_NOTA: alu_r_s = ~bus.a;
            default: alu_r_s = {WIDTH{1'b0}};
        endcase
        alu_zero_s = (alu_r_s == {WIDTH{1'b0}});
        alu_sign_s = alu_r_s[WIDTH-1];
    end

    // One shift-add step: conditional add into the high half, then shift right with carry.
    always_comb begin
        if (mplier_q[0]) begin
            step_sum_s = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mcand_q};
        end else begin
            step_sum_s = {1'b0, acc_q[2*WIDTH-1:WIDTH]};
        end
        acc_step_s = {step_sum_s, acc_q[WIDTH-1:1]};
    end

    // Controller next state; outputs hold unless an operation completes.
    always_comb begin
        state_d  = state_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        r_d      = r_q;
        r_hi_d   = r_hi_q;
        zero_d   = zero_q;
        carry_d  = carry_q;
        sign_d   = sign_q;
        ovf_d    = ovf_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start && (bus.op == OP_MUL)) begin
                    mcand_d  = bus.a;
                    mplier_d = bus.b;
                    acc_d    = {(2*WIDTH){1'b0}};
                    cnt_d    = {CNT_W{1'b0}};
                    busy_d   = 1'b1;
                    state_d  = ST_MUL;
                end else if (bus.start) begin
                    r_d     = alu_r_s;
                    r_hi_d  = {WIDTH{1'b0}};
                    zero_d  = alu_zero_s;
                    carry_d = alu_carry_s;
                    sign_d  = alu_sign_s;
                    ovf_d   = alu_ovf_s;
                    done_d  = 1'b1;
                end else begin
                    done_d = 1'b0;
                end
            end
            ST_MUL: begin
                acc_d    = acc_step_s;
                mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_ITER) begin
                    r_d     = acc_step_s[WIDTH-1:0];
                    r_hi_d  = acc_step_s[2*WIDTH-1:WIDTH];
                    zero_d  = (acc_step_s == {(2*WIDTH){1'b0}});
                    carry_d = (acc_step_s[2*WIDTH-1:WIDTH] != {WIDTH{1'b0}});
                    sign_d  = acc_step_s[2*WIDTH-1];
                    ovf_d   = 1'b0;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    busy_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any multiply in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            r_q      <= {WIDTH{1'b0}};
            r_hi_q   <= {WIDTH{1'b0}};
            zero_q   <= 1'b0;
            carry_q  <= 1'b0;
            sign_q   <= 1'b0;
            ovf_q    <= 1'b0;
            mcand_q  <= {WIDTH{1'b0}};
            mplier_q <= {WIDTH{1'b0}};
            acc_q    <= {(2*WIDTH){1'b0}};
            cnt_q    <= {CNT_W{1'b0}};
        end else begin
            state_q  <= state_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            r_q      <= r_d;
            r_hi_q   <= r_hi_d;
            zero_q   <= zero_d;
            carry_q  <= carry_d;
            sign_q   <= sign_d;
            ovf_q    <= ovf_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.r        = r_q;
    assign bus.r_hi     = r_hi_q;
    assign bus.zero     = zero_q;
    assign bus.carry    = carry_q;
    assign bus.sign     = sign_q;
    assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at WIDTH=8. Observed word packs
// {done, busy, r_hi, r, zero, carry, sign, overflow}.
module tb_alu_seq;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    alu_seq_if #(.WIDTH(8)) bus ();

    alu_seq #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [21:0] obs();
        return {bus.done, bus.busy, bus.r_hi, bus.r,
                bus.zero, bus.carry, bus.sign, bus.overflow};
    endfunction

    function automatic logic [21:0] mk(input logic d, input logic bz, input logic [7:0] hi,
                                       input logic [7:0] lo, input logic [3:0] fl);
        return {d, bz, hi, lo, fl};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic st, input logic [3:0] o, input logic [7:0] a, input logic [7:0] b);
        bus.start = st;
        bus.op    = o;
        bus.a     = a;
        bus.b     = b;
    endtask

    task automatic test_reset();
        logic [21:0] got;
        rst_n = 1'b0;
        drive(1'b0, 4'd0, 8'h00, 8'h00);
        repeat (2) @(posedge clk);
        #1;
        got = obs();
        total++;
        if (got !== 22'h0) begin
            bad++;
            $display("FAIL reset_state: got=%h want=%h", got, 22'h0);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_add();
        logic [21:0] got;
        drive(1'b1, 4'd1, 8'h7F, 8'h01);
        tick();
        drive(1'b0, 4'd0, 8'h00, 8'h00);
        got = obs();
        total++;
        if (got !== mk(1'b1, 1'b0, 8'h00, 8'h80, 4'b0011)) begin
            bad++;
            $display("FAIL add_7f_01: got=%h want=%h", got, mk(1'b1, 1'b0, 8'h00, 8'h80, 4'b0011));
        end
        tick();
        got = obs();
        total++;
        if (got !== mk(1'b0, 1'b0, 8'h00, 8'h80, 4'b0011)) begin
            bad++;
            $display("FAIL add_hold: got=%h want=%h", got, mk(1'b0, 1'b0, 8'h00, 8'h80, 4'b0011));
        end
    endtask

    task automatic test_sub();
        logic [21:0] got;
        drive(1'b1, 4'd0, 8'h05, 8'h05);
        tick();
        got = obs();
        total++;
        if (got !== mk(1'b1, 1'b0, 8'h00, 8'h00, 4'b1100)) begin
            bad++;
            $display("FAIL sub_5_5: got=%h want=%h", got, mk(1'b1, 1'b0, 8'h00, 8'h00, 4'b1100));
        end
        drive(1'b1, 4'd0, 8'h03, 8'h05);
        tick();
        drive(1'b0, 4'd0, 8'h00, 8'h00);
        got = obs();
        total++;
        if (got !== mk(1'b1, 1'b0, 8'h00, 8'hFE, 4'b0010)) begin
            bad++;
            $display("FAIL sub_3_5_b2b: got=%h want=%h", got, mk(1'b1, 1'b0, 8'h00, 8'hFE, 4'b0010));
        end
        tick();
    endtask

    task automatic test_neg_logic();
        logic [21:0] got;
        logic [3:0]  ops  [7] = '{4'd3, 4'd3, 4'd6, 4'd2, 4'd4, 4'd5, 4'd7};
        logic [7:0]  va   [7] = '{8'h80, 8'h00, 8'hF0, 8'h00, 8'hF0, 8'hF0, 8'h55};
        logic [7:0]  vb   [7] = '{8'h00, 8'h00, 8'hFF, 8'h01, 8'h3C, 8'h0F, 8'h00};
        logic [7:0]  er   [7] = '{8'h80, 8'h00, 8'h0F, 8'hFF, 8'h30, 8'hFF, 8'hAA};
        logic [3:0]  ef   [7] = '{4'b0011, 4'b1100, 4'b0000, 4'b0010, 4'b0000, 4'b0010, 4'b0010};
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, ops[i], va[i], vb[i]);
            tick();
            got = obs();
            total++;
            if (got !== mk(1'b1, 1'b0, 8'h00, er[i], ef[i])) begin
                bad++;
                $display("FAIL neg_logic_%0d: got=%h want=%h", i, got, mk(1'b1, 1'b0, 8'h00, er[i], ef[i]));
            end
        end
        drive(1'b0, 4'd0, 8'h00, 8'h00);
        tick();
    endtask

    task automatic test_mul_ff();
        logic [21:0] got;
        logic [21:0] held;
        held = mk(1'b0, 1'b0, 8'h00, 8'hAA, 4'b0010);
        drive(1'b1, 4'd8, 8'hFF, 8'hFF);
        tick();
        got = obs();
        total++;
        if (got !== mk(1'b0, 1'b1, 8'h00, 8'hAA, 4'b0010)) begin
            bad++;
            $display("FAIL mul_capture: got=%h want=%h", got, mk(1'b0, 1'b1, 8'h00, 8'hAA, 4'b0010));
        end
        for (int k = 1; k <= 8; k++) begin
            if (k == 2 || k == 4) drive(1'b1, 4'd1, 8'h01, 8'h01);
            else drive(1'b0, 4'd0, 8'h00, 8'h00);
            tick();
            got = obs();
            total++;
            if (k < 8) begin
                if (got !== (held | mk(1'b0, 1'b1, 8'h00, 8'h00, 4'b0000))) begin
                    bad++;
                    $display("FAIL mul_busy_edge%0d: got=%h want=%h", k, got,
                             held | mk(1'b0, 1'b1, 8'h00, 8'h00, 4'b0000));
                end
            end else begin
                if (got !== mk(1'b1, 1'b0, 8'hFE, 8'h01, 4'b0110)) begin
                    bad++;
                    $display("FAIL mul_ff_done: got=%h want=%h", got, mk(1'b1, 1'b0, 8'hFE, 8'h01, 4'b0110));
                end
            end
        end
        drive(1'b0, 4'd0, 8'h00, 8'h00);
        tick();
        got = obs();
        total++;
        if (got !== mk(1'b0, 1'b0, 8'hFE, 8'h01, 4'b0110)) begin
            bad++;
            $display("FAIL mul_ff_single_done: got=%h want=%h", got, mk(1'b0, 1'b0, 8'hFE, 8'h01, 4'b0110));
        end
    endtask

    task automatic test_reserved_mul_zero();
        logic [21:0] got;
        int          lat;
        drive(1'b1, 4'd12, 8'h12, 8'h34);
        tick();
        drive(1'b0, 4'd0, 8'h00, 8'h00);
        got = obs();
        total++;
        if (got !== mk(1'b1, 1'b0, 8'h00, 8'h00, 4'b1000)) begin
            bad++;
            $display("FAIL reserved_12: got=%h want=%h", got, mk(1'b1, 1'b0, 8'h00, 8'h00, 4'b1000));
        end
        drive(1'b1, 4'd1, 8'h01, 8'h01);
        tick();
        drive(1'b1, 4'd8, 8'h00, 8'h9C);
        tick();
        drive(1'b0, 4'd0, 8'h00, 8'h00);
        lat = 0;
        while (bus.done !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        total++;
        if (lat !== 8) begin
            bad++;
            $display("FAIL mul_zero_latency: got=%0d want=%0d", lat, 8);
        end
        got = obs();
        total++;
        if (got !== mk(1'b1, 1'b0, 8'h00, 8'h00, 4'b1000)) begin
            bad++;
            $display("FAIL mul_zero_result: got=%h want=%h", got, mk(1'b1, 1'b0, 8'h00, 8'h00, 4'b1000));
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [21:0] got;
        drive(1'b1, 4'd8, 8'h0D, 8'h0B);
        tick();
        drive(1'b1, 4'd1, 8'h02, 8'h03);
        repeat (8) tick();
        got = obs();
        total++;
        if (got !== mk(1'b1, 1'b0, 8'h00, 8'h8F, 4'b0000)) begin
            bad++;
            $display("FAIL mul_0d_0b: got=%h want=%h", got, mk(1'b1, 1'b0, 8'h00, 8'h8F, 4'b0000));
        end
        tick();
        drive(1'b0, 4'd0, 8'h00, 8'h00);
        got = obs();
        total++;
        if (got !== mk(1'b1, 1'b0, 8'h00, 8'h05, 4'b0000)) begin
            bad++;
            $display("FAIL start_on_done: got=%h want=%h", got, mk(1'b1, 1'b0, 8'h00, 8'h05, 4'b0000));
        end
        tick();
    endtask

    task automatic test_reset_mid_mul();
        logic [21:0] got;
        drive(1'b1, 4'd8, 8'hFF, 8'hFF);
        tick();
        drive(1'b0, 4'd0, 8'h00, 8'h00);
        repeat (3) tick();
        #2;
        rst_n = 1'b0;
        #1;
        got = obs();
        total++;
        if (got !== 22'h0) begin
            bad++;
            $display("FAIL reset_mid_mul: got=%h want=%h", got, 22'h0);
        end
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (8) tick();
        got = obs();
        total++;
        if (got !== 22'h0) begin
            bad++;
            $display("FAIL reset_no_done: got=%h want=%h", got, 22'h0);
        end
        drive(1'b1, 4'd1, 8'h10, 8'h20);
        tick();
        drive(1'b0, 4'd0, 8'h00, 8'h00);
        got = obs();
        total++;
        if (got !== mk(1'b1, 1'b0, 8'h00, 8'h30, 4'b0000)) begin
            bad++;
            $display("FAIL add_after_reset: got=%h want=%h", got, mk(1'b1, 1'b0, 8'h00, 8'h30, 4'b0000));
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_add();
        test_sub();
        test_neg_logic();
        test_mul_ff();
        test_reserved_mul_zero();
        test_back_to_back();
        test_reset_mid_mul();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got=running want=finished");
        $fatal(1, "timeout");
    end

endmodule
